// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   state_t : fetch FSM states (boot, run, halt)
//   NOP_INS : instruction word placed in IF/ID on reset and flush
//   PC_STEP : byte increment between sequential instructions
package fetch_pkg;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INS = 32'h0000_0000;
    localparam int unsigned PC_STEP = 4;

endpackage : fetch_pkg

// File: rtl/fetch_stage_pcreg.sv
// Parameterised enable register with synchronous active-high reset; holds the PC.
//   clk   : rising-edge clock
//   reset : synchronous reset, loads RESET_VAL
//   en    : load d on the next edge
//   d     : next value
//   q     : registered value
module fetch_stage_pcreg #(
    parameter int unsigned    WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : fetch_stage_pcreg

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and loads
// the IF/ID register for decode. Handles decode stall, branch/jump redirect,
// halt, and counts instructions handed to decode.
// Optional feature macro: BRANCH_DELAY_SLOT_EN (MIPS delay slot with a
// one-entry pending-redirect register); without it a redirect flushes IF/ID.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   imem_addr         : instruction address (the PC register itself)
//   imem_rdata        : instruction word at imem_addr, same cycle
//   dec_ready         : decode accepts IF/ID this cycle
//   redirect_en/target: branch/jump taken and its destination
//   halt_req          : stop fetching until reset
//   if_pc/pc4/ins/valid : IF/ID register contents
//   misalign_err      : sticky, a redirect target was not word aligned
//   fetch_count       : instructions accepted by decode (wraps)
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [31:0]      imem_rdata,
    input  logic             dec_ready,
    input  logic             redirect_en,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             halt_req,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_pc4,
    output logic [31:0]      if_ins,
    output logic             if_valid,
    output logic             misalign_err,
    output logic [WIDTH-1:0] fetch_count
);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] tgt_aligned;
    logic [WIDTH-1:0] take_tgt;
    logic             run;
    logic             advance;
    logic             take;
    logic             pc_en;
    logic             load_ifid;
    logic             flush;

    assign run         = (state == S_RUN);
    assign advance     = run & (dec_ready | ~if_valid);
    assign pc_plus4    = pc + WIDTH'(PC_STEP);
    assign tgt_aligned = {redirect_target[WIDTH-1:2], 2'b00};
    assign imem_addr   = pc;

`ifdef BRANCH_DELAY_SLOT_EN
    // Redirect seen during a stall waits here until the slot instruction moves on.
    logic             pend_v;
    logic [WIDTH-1:0] pend_t;

    assign take      = advance & (redirect_en | pend_v);
    assign take_tgt  = redirect_en ? tgt_aligned : pend_t;
    assign pc_en     = advance;
    assign load_ifid = advance;
    assign flush     = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_v <= 1'b0;
            pend_t <= '0;
        end else if (advance) begin
            pend_v <= 1'b0;
        end else if (run && redirect_en) begin
            pend_v <= 1'b1;
            pend_t <= tgt_aligned;
        end
    end
`else
    // Without a delay slot the wrong-path instruction in IF is discarded.
    assign take      = run & redirect_en;
    assign take_tgt  = tgt_aligned;
    assign pc_en     = advance | take;
    assign load_ifid = advance & ~redirect_en;
    assign flush     = take;
`endif

    assign pc_d = take ? take_tgt : pc_plus4;

    fetch_stage_pcreg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_PC)
    ) u_pcreg (
        .clk   (clk),
        .reset (reset),
        .en    (pc_en),
        .d     (pc_d),
        .q     (pc)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_BOOT;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: one boot cycle, run until halt, halt until reset.
    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_RUN;
            S_RUN:   if (halt_req) state_nxt = S_HALT;
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_BOOT;
        endcase
    end

    // IF/ID pipeline register.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_pc    <= '0;
            if_pc4   <= '0;
            if_ins   <= NOP_INS;
            if_valid <= 1'b0;
        end else if (flush) begin
            if_ins   <= NOP_INS;
            if_valid <= 1'b0;
        end else if (load_ifid) begin
            if_pc    <= pc;
            if_pc4   <= pc_plus4;
            if_ins   <= imem_rdata;
            if_valid <= 1'b1;
        end else if ((state == S_HALT) && dec_ready) begin
            if_valid <= 1'b0;
        end
    end

    // Sticky misaligned-target flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_err <= 1'b0;
        end else if (run && redirect_en && (redirect_target[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end

    // Delivered-instruction counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= '0;
        end else if (if_valid && dec_ready) begin
            fetch_count <= fetch_count + WIDTH'(1);
        end
    end

endmodule : fetch_stage
